uart_tx: RTL and testbench

//  Serial UART transmitter that drains the sender-side FIFO (read side) and shifts words out on tx.

---
 rtl/uart_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_tx.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter that drains a show-ahead TX FIFO.
//   Each frame pops one FIFO word and sends a start bit, DBIT data bits
//   LSB first, an optional parity bit and the stop period. Bit timing is
//   counted in s_tick strobes: OS per start/data/parity bit, SB_TICK for the
//   stop period.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   s_tick     in   one-clk baud oversampling strobe
//   fifo_empty in   FIFO empty flag
//   fifo_data  in   FIFO head word (valid while fifo_empty=0)
//   fifo_rd    out  one-clk pop pulse to the FIFO
//   tx         out  serial line, idle high
//   tx_busy    out  high while a frame is in progress
//   tx_done    out  one-clk pulse at the end of the stop period
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int OS      = 16,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int TMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(DBIT);
  localparam logic [TW-1:0] OS_LAST  = TW'(OS - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            rd_q, rd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Line level of the parity bit given the XOR of all data bits.
  function automatic logic parity_bit(input logic data_xor);
    return (PARITY == 2) ? ~data_xor : data_xor;
  endfunction

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // Latch the head word and pop it; the start bit goes out on this edge.
        if (!fifo_empty) begin
          shreg_d = fifo_data;
          rd_d    = 1'b1;
          tick_d  = '0;
          par_d   = 1'b0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = DATA;
            tx_d    = shreg_q[0];
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            shreg_d = shreg_q >> 1;
            par_d   = par_q ^ shreg_q[0];
            if (bit_q == BIT_LAST) begin
              if (PARITY != 0) begin
                state_d = PAR;
                tx_d    = parity_bit(par_q ^ shreg_q[0]);
              end else begin
                state_d = STOP;
                tx_d    = 1'b1;
              end
            end else begin
              bit_d = bit_q + BW'(1);
              // Next bit is the one about to land in shreg[0].
              tx_d  = shreg_q[1];
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      PAR: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (tick_q == SB_LAST) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign fifo_rd = rd_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. Four instances share clk, reset
// and s_tick (one strobe every 4 clks): u0 no parity, u1 even parity,
// u2 odd parity, u3 no parity with SB_TICK=32. Each has its own FIFO model.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic s_tick;

  logic [7:0] mem [4][16];
  int         wr_ptr   [4] = '{default: 0};
  int         rd_ptr   [4] = '{default: 0};
  int         rd_cnt   [4] = '{default: 0};
  int         done_cnt [4] = '{default: 0};
  logic       fempty [4];
  logic [7:0] fdata  [4];
  logic       frd    [4];
  logic       tx     [4];
  logic       busy   [4];
  logic       done   [4];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fempty[i] = (rd_ptr[i] == wr_ptr[i]);
      fdata[i]  = mem[i][rd_ptr[i] % 16];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (frd[i] === 1'b1) begin
        rd_ptr[i] <= rd_ptr[i] + 1;
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
      if (done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  uart_tx #(.DBIT(8), .OS(16), .SB_TICK(16), .PARITY(0)) u0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fempty[0]),
    .fifo_data(fdata[0]), .fifo_rd(frd[0]), .tx(tx[0]), .tx_busy(busy[0]),
    .tx_done(done[0]));
  uart_tx #(.DBIT(8), .OS(16), .SB_TICK(16), .PARITY(1)) u1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fempty[1]),
    .fifo_data(fdata[1]), .fifo_rd(frd[1]), .tx(tx[1]), .tx_busy(busy[1]),
    .tx_done(done[1]));
  uart_tx #(.DBIT(8), .OS(16), .SB_TICK(16), .PARITY(2)) u2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fempty[2]),
    .fifo_data(fdata[2]), .fifo_rd(frd[2]), .tx(tx[2]), .tx_busy(busy[2]),
    .tx_done(done[2]));
  uart_tx #(.DBIT(8), .OS(16), .SB_TICK(32), .PARITY(0)) u3 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fempty[3]),
    .fifo_data(fdata[3]), .fifo_rd(frd[3]), .tx(tx[3]), .tx_busy(busy[3]),
    .tx_done(done[3]));

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  task automatic push(input int i, input logic [7:0] d);
    mem[i][wr_ptr[i] % 16] = d;
    wr_ptr[i] = wr_ptr[i] + 1;
  endtask

  // Poll tx of instance i at negedges until it equals lvl; t=-1 on timeout.
  task automatic wait_tx(input int i, input logic lvl, output int t);
    int n = 0;
    while (tx[i] !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    t = (n >= 3000) ? -1 : cyc;
  endtask

  task automatic wait_done(input int i, output int t);
    int n = 0;
    while (done[i] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    t = (n >= 3000) ? -1 : cyc;
  endtask

  // Sample nb bits of a frame at bit centres (start bit first).
  task automatic capture(input int i, input int nb, output logic [10:0] got);
    int t;
    got = '0;
    wait_tx(i, 1'b0, t);
    if (t < 0) begin
      got = 'x;
    end else begin
      repeat (32) @(negedge clk);
      for (int k = 0; k < nb; k++) begin
        if (k > 0) repeat (64) @(negedge clk);
        got[k] = tx[i];
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({tx[i], busy[i], frd[i], done[i]} !== 4'b1000) begin
        failures++;
        $display("FAIL reset_state inst%0d: {tx,busy,rd,done} got %b expected 1000",
                 i, {tx[i], busy[i], frd[i], done[i]});
      end
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    logic [10:0] got;
    int rc, dc, t, t1, t2;
    rc = rd_cnt[0];
    dc = done_cnt[0];
    push(0, 8'hA5);
    capture(0, 10, got);
    checks++;
    if (got !== 11'b01_1010_0101_0) begin
      failures++;
      $display("FAIL frame_A5: got %b expected %b", got, 11'b01_1010_0101_0);
    end
    wait_done(0, t);
    repeat (3) @(negedge clk);
    checks++;
    if (rd_cnt[0] - rc !== 1) begin
      failures++;
      $display("FAIL single_rd_cycles: got %0d expected 1", rd_cnt[0] - rc);
    end
    checks++;
    if (done_cnt[0] - dc !== 1) begin
      failures++;
      $display("FAIL single_done_pulses: got %0d expected 1", done_cnt[0] - dc);
    end
    checks++;
    if ({busy[0], tx[0]} !== 2'b01) begin
      failures++;
      $display("FAIL single_idle_after: {busy,tx} got %b expected 01", {busy[0], tx[0]});
    end
    // Data bit 0 of 0xA5 is 1 and bit 1 is 0: that bit lasts exactly 64 clks.
    push(0, 8'hA5);
    wait_tx(0, 1'b0, t);
    wait_tx(0, 1'b1, t1);
    wait_tx(0, 1'b0, t2);
    checks++;
    if (t1 < 0 || t2 - t1 !== 64) begin
      failures++;
      $display("FAIL bit_period: got %0d clks expected 64", t2 - t1);
    end
    wait_done(0, t);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_parity();
    logic [10:0] got;
    int t;
    // u1 even: 0xA5 has four ones -> 0; 0x01 -> 1. u2 odd is the inverse.
    push(1, 8'hA5);
    push(1, 8'h01);
    capture(1, 11, got);
    checks++;
    if (got !== {1'b1, 1'b0, 8'hA5, 1'b0}) begin
      failures++;
      $display("FAIL even_A5: got %b expected %b", got, {1'b1, 1'b0, 8'hA5, 1'b0});
    end
    capture(1, 11, got);
    checks++;
    if (got !== {1'b1, 1'b1, 8'h01, 1'b0}) begin
      failures++;
      $display("FAIL even_01: got %b expected %b", got, {1'b1, 1'b1, 8'h01, 1'b0});
    end
    wait_done(1, t);
    push(2, 8'hA5);
    push(2, 8'h01);
    capture(2, 11, got);
    checks++;
    if (got !== {1'b1, 1'b1, 8'hA5, 1'b0}) begin
      failures++;
      $display("FAIL odd_A5: got %b expected %b", got, {1'b1, 1'b1, 8'hA5, 1'b0});
    end
    capture(2, 11, got);
    checks++;
    if (got !== {1'b1, 1'b0, 8'h01, 1'b0}) begin
      failures++;
      $display("FAIL odd_01: got %b expected %b", got, {1'b1, 1'b0, 8'h01, 1'b0});
    end
    wait_done(2, t);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  words [3] = '{8'h00, 8'hFF, 8'h3C};
    logic [10:0] got;
    int rc, t;
    rc = rd_cnt[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    for (int j = 0; j < 3; j++) begin
      capture(0, 10, got);
      checks++;
      if (got !== {2'b01, words[j], 1'b0}) begin
        failures++;
        $display("FAIL b2b_frame%0d: got %b expected %b", j, got, {2'b01, words[j], 1'b0});
      end
      wait_done(0, t);
      if (j < 2) begin
        // Next pop and start bit land exactly one clk after the done edge.
        checks++;
        if (frd[0] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_rd_early%0d: got %b expected 0", j, frd[0]);
        end
        @(negedge clk);
        checks++;
        if ({frd[0], tx[0]} !== 2'b10) begin
          failures++;
          $display("FAIL b2b_restart%0d: {rd,tx} got %b expected 10", j, {frd[0], tx[0]});
        end
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rd_cnt[0] - rc !== 3 || fempty[0] !== 1'b1 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: pops got %0d empty %b busy %b expected 3 1 0",
               rd_cnt[0] - rc, fempty[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid();
    int t, rc, bad;
    push(0, 8'h55);
    wait_tx(0, 1'b0, t);
    repeat (32 + 64 * 4) @(negedge clk);
    checks++;
    if (tx[0] !== 1'b0) begin
      failures++;
      $display("FAIL mid_bit3: tx got %b expected 0", tx[0]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({tx[0], busy[0], frd[0], done[0]} !== 4'b1000) begin
      failures++;
      $display("FAIL mid_reset_async: {tx,busy,rd,done} got %b expected 1000",
               {tx[0], busy[0], frd[0], done[0]});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rc = rd_cnt[0];
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || rd_cnt[0] !== rc) begin
      failures++;
      $display("FAIL after_reset_idle: bad cycles %0d pops %0d expected 0 0", bad, rd_cnt[0] - rc);
    end
  endtask

  task automatic test_idle();
    int rc, bad;
    rc = rd_cnt[0];
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || frd[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL idle_line: bad cycles got %0d expected 0", bad);
    end
    checks++;
    if (rd_cnt[0] !== rc) begin
      failures++;
      $display("FAIL idle_pops: got %0d expected 0", rd_cnt[0] - rc);
    end
  endtask

  task automatic test_stop32();
    int t, t1, t2;
    push(3, 8'h7F);
    wait_tx(3, 1'b0, t);
    repeat (32 + 64 * 8) @(negedge clk);
    checks++;
    if (tx[3] !== 1'b0) begin
      failures++;
      $display("FAIL stop32_bit7: tx got %b expected 0", tx[3]);
    end
    wait_tx(3, 1'b1, t1);
    wait_done(3, t2);
    checks++;
    if (t1 < 0 || t2 < 0 || t2 - t1 !== 128) begin
      failures++;
      $display("FAIL stop32_period: got %0d clks expected 128", t2 - t1);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    test_stop32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
